// File: rtl/bsg_nonsynth_axi_mem_trace_replay.sv
// Replays WR/RD trace entries as single-beat AXI4 transactions, one outstanding at a time.
// Read data is compared against the expected word under a byte mask; status and counters are sticky.
module bsg_nonsynth_axi_mem_trace_replay #(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64,
  parameter int mem_els_p = 64,
  parameter int cnt_width_p = 32,
  localparam int lg_mem_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1,
  localparam int axi_strb_width_lp = axi_data_width_p >> 3,
  localparam int lg_strb_lp = (axi_strb_width_lp > 1) ? $clog2(axi_strb_width_lp) : 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic                         tr_v_i,
  output logic                         tr_yumi_o,
  input  logic                         tr_wr_i,
  input  logic                         tr_last_i,
  input  logic [lg_mem_els_lp-1:0]     tr_idx_i,
  input  logic [axi_data_width_p-1:0]  tr_data_i,
  input  logic [axi_strb_width_lp-1:0] tr_strb_i,

  output logic [axi_addr_width_p-1:0]  m_axi_awaddr_o,
  output logic                         m_axi_awvalid_o,
  input  logic                         m_axi_awready_i,

  output logic [axi_data_width_p-1:0]  m_axi_wdata_o,
  output logic [axi_strb_width_lp-1:0] m_axi_wstrb_o,
  output logic                         m_axi_wlast_o,
  output logic                         m_axi_wvalid_o,
  input  logic                         m_axi_wready_i,

  input  logic [1:0]                   m_axi_bresp_i,
  input  logic                         m_axi_bvalid_i,
  output logic                         m_axi_bready_o,

  output logic [axi_addr_width_p-1:0]  m_axi_araddr_o,
  output logic                         m_axi_arvalid_o,
  input  logic                         m_axi_arready_i,

  input  logic [axi_data_width_p-1:0]  m_axi_rdata_i,
  input  logic [1:0]                   m_axi_rresp_i,
  input  logic                         m_axi_rlast_i,
  input  logic                         m_axi_rvalid_i,
  output logic                         m_axi_rready_o,

  output logic                         done_o,
  output logic                         error_o,
  output logic [cnt_width_p-1:0]       mismatch_cnt_o,
  output logic [cnt_width_p-1:0]       op_cnt_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

  state_e                        state_r;
  logic                          last_r, aw_sent_r, w_sent_r, error_r;
  logic [axi_addr_width_p-1:0]   addr_r;
  logic [axi_data_width_p-1:0]   data_r, mask;
  logic [axi_strb_width_lp-1:0]  strb_r;
  logic [cnt_width_p-1:0]        op_cnt_r, mismatch_cnt_r;
  logic [axi_addr_width_p-1:0]   tr_addr;
  logic                          aw_done, w_done, b_fire, r_fire, resp_err, mismatch;

  assign tr_addr = axi_addr_width_p'(tr_idx_i) << lg_strb_lp;

  assign tr_yumi_o       = (state_r == IDLE) & tr_v_i & ~reset_i;
  assign m_axi_awvalid_o = (state_r == WR_REQ) & ~aw_sent_r;
  assign m_axi_wvalid_o  = (state_r == WR_REQ) & ~w_sent_r;
  assign m_axi_bready_o  = (state_r == WR_RESP);
  assign m_axi_arvalid_o = (state_r == RD_REQ);
  assign m_axi_rready_o  = (state_r == RD_RESP);
  assign m_axi_wlast_o   = 1'b1;
  assign m_axi_awaddr_o  = addr_r;
  assign m_axi_araddr_o  = addr_r;
  assign m_axi_wdata_o   = data_r;
  assign m_axi_wstrb_o   = strb_r;
  assign done_o          = (state_r == DONE);
  assign error_o         = error_r;
  assign op_cnt_o        = op_cnt_r;
  assign mismatch_cnt_o  = mismatch_cnt_r;

  // AW and W complete independently; a flag remembers a handshake that landed early.
  assign aw_done = aw_sent_r | (m_axi_awvalid_o & m_axi_awready_i);
  assign w_done  = w_sent_r  | (m_axi_wvalid_o  & m_axi_wready_i);

  assign b_fire   = m_axi_bready_o & m_axi_bvalid_i;
  assign r_fire   = m_axi_rready_o & m_axi_rvalid_i;
  assign resp_err = (b_fire & (m_axi_bresp_i != 2'b00))
                  | (r_fire & ((m_axi_rresp_i != 2'b00) | ~m_axi_rlast_i));

  always_comb begin
    mask = '0;
    for (int i = 0; i < axi_strb_width_lp; i++) begin
      mask[i*8 +: 8] = {8{strb_r[i]}};
    end
  end

  assign mismatch = |((m_axi_rdata_i ^ data_r) & mask);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r        <= IDLE;
      last_r         <= 1'b0;
      aw_sent_r      <= 1'b0;
      w_sent_r       <= 1'b0;
      error_r        <= 1'b0;
      addr_r         <= '0;
      data_r         <= '0;
      strb_r         <= '0;
      op_cnt_r       <= '0;
      mismatch_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tr_v_i) begin
            last_r  <= tr_last_i;
            addr_r  <= tr_addr;
            data_r  <= tr_data_i;
            strb_r  <= tr_strb_i;
            state_r <= tr_wr_i ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_done && w_done) begin
            state_r   <= WR_RESP;
            aw_sent_r <= 1'b0;
            w_sent_r  <= 1'b0;
          end else begin
            aw_sent_r <= aw_done;
            w_sent_r  <= w_done;
          end
        end
        RD_REQ: begin
          if (m_axi_arready_i) state_r <= RD_RESP;
        end
        WR_RESP, RD_RESP: begin
          if (b_fire || r_fire) begin
            if (resp_err) error_r <= 1'b1;
            if (op_cnt_r != '1) op_cnt_r <= op_cnt_r + cnt_width_p'(1);
            if (r_fire && mismatch && (mismatch_cnt_r != '1))
              mismatch_cnt_r <= mismatch_cnt_r + cnt_width_p'(1);
            state_r <= last_r ? DONE : IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_nonsynth_axi_mem_trace_replay.sv
// Bench: AXI slave with stall/error knobs plus a trace-level model of counters and status.
module tb_bsg_nonsynth_axi_mem_trace_replay;

  localparam int CW = 4;
  localparam int SAT = 15;

  logic clk_i, reset_i;
  logic tr_v_i, tr_yumi_o, tr_wr_i, tr_last_i;
  logic [5:0] tr_idx_i;
  logic [63:0] tr_data_i;
  logic [7:0] tr_strb_i;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready;
  logic rlast, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic done_o, error_o;
  logic [CW-1:0] mismatch_cnt_o, op_cnt_o;

  bsg_nonsynth_axi_mem_trace_replay #(
    .axi_addr_width_p(64), .axi_data_width_p(64), .mem_els_p(64), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .tr_v_i(tr_v_i), .tr_yumi_o(tr_yumi_o), .tr_wr_i(tr_wr_i), .tr_last_i(tr_last_i),
    .tr_idx_i(tr_idx_i), .tr_data_i(tr_data_i), .tr_strb_i(tr_strb_i),
    .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .done_o(done_o), .error_o(error_o), .mismatch_cnt_o(mismatch_cnt_o), .op_cnt_o(op_cnt_o)
  );

  int checks = 0, failures = 0, cyc = 0;

  // trace and per-op slave fault injection
  int n_tr = 0;
  bit t_wr [40];
  logic [5:0] t_idx [40];
  logic [63:0] t_data [40];
  logic [7:0] t_strb [40];
  logic [1:0] inj_b [40], inj_rr [40];
  bit inj_rl0 [40];
  int e_op [41], e_mm [41];
  bit e_err [41];
  logic [63:0] smem [64], mmem [64];

  int n_acc = 0, n_req = 0, n_done = 0;
  int aw_stall = 0, w_stall = 0, ar_stall = 0;
  int aw_vcyc = 0, w_vcyc = 0, yumi_cyc [40];
  logic [63:0] s_last_awaddr;
  logic [7:0] s_last_wstrb;
  bit cmp_en = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Trace-level model: replay entries over a word memory, accumulate counts with saturation.
  task automatic build_model();
    int op = 0, mm = 0;
    bit err = 0;
    logic [63:0] bm;
    e_op[0] = 0; e_mm[0] = 0; e_err[0] = 0;
    for (int k = 0; k < n_tr; k++) begin
      for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{t_strb[k][b]}};
      if (t_wr[k]) begin
        mmem[t_idx[k]] = (mmem[t_idx[k]] & ~bm) | (t_data[k] & bm);
        if (inj_b[k] != 0) err = 1;
      end else begin
        if (((mmem[t_idx[k]] ^ t_data[k]) & bm) != 0) mm++;
        if (inj_rr[k] != 0 || inj_rl0[k]) err = 1;
      end
      op++;
      e_op[k+1] = (op > SAT) ? SAT : op;
      e_mm[k+1] = (mm > SAT) ? SAT : mm;
      e_err[k+1] = err;
    end
  endtask

  task automatic set_entry(input int k, input bit wr, input logic [5:0] idx,
                           input logic [63:0] d, input logic [7:0] s);
    t_wr[k] = wr; t_idx[k] = idx; t_data[k] = d; t_strb[k] = s;
    inj_b[k] = 0; inj_rr[k] = 0; inj_rl0[k] = 0;
  endtask

  task automatic gen_random(input int n, input bit with_err);
    logic [63:0] g [64];
    logic [63:0] bm;
    for (int i = 0; i < 64; i++) g[i] = mmem[i];
    n_tr = n;
    for (int k = 0; k < n; k++) begin
      set_entry(k, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), {$urandom, $urandom},
                ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
      for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{t_strb[k][b]}};
      if (t_wr[k]) g[t_idx[k]] = (g[t_idx[k]] & ~bm) | (t_data[k] & bm);
      else if ($urandom_range(0, 1) == 1) t_data[k] = g[t_idx[k]];
      if (with_err && $urandom_range(0, 9) == 0) inj_b[k] = 2'($urandom_range(1, 3));
      if (with_err && $urandom_range(0, 9) == 0) inj_rr[k] = 2'($urandom_range(1, 3));
      if (with_err && $urandom_range(0, 9) == 0) inj_rl0[k] = 1;
    end
  endtask

  task automatic do_reset();
    reset_i = 1; n_acc = 0; n_tr = 0;
    repeat (2) @(posedge clk_i);
    #2 reset_i = 0;
    @(posedge clk_i); #1;
  endtask

  // Presents entries in order, holding each until consumed; optional random idle gaps.
  task automatic drive_all(input int gap_max);
    int k = 0, guard = 0;
    bit acc;
    while (k < n_tr && guard < 3000) begin
      guard++;
      if (gap_max > 0 && $urandom_range(0, gap_max) == 0) begin
        tr_v_i = 0; tr_idx_i = 6'($urandom); tr_wr_i = 1'($urandom);
      end else begin
        tr_v_i = 1; tr_wr_i = t_wr[k]; tr_idx_i = t_idx[k]; tr_data_i = t_data[k];
        tr_strb_i = t_strb[k]; tr_last_i = (k == n_tr - 1);
      end
      @(negedge clk_i);
      acc = tr_yumi_o;
      if (acc) yumi_cyc[k] = cyc;
      @(posedge clk_i); #1;
      if (acc) begin k++; n_acc++; end
    end
    tr_v_i = 0;
    check("drive_timeout_entries", 64'(k), 64'(n_tr));
  endtask

  task automatic wait_done(input int lim);
    int c = 0;
    while (!done_o && c < lim) begin @(negedge clk_i); c++; end
    check("done_timeout", 64'(done_o), 64'(1));
    @(posedge clk_i); #1;
  endtask

  // AXI slave: decides handshakes from values seen at negedge, updates after the edge.
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, awv, wv, arv, got_aw, got_w, s_wlast;
    logic [63:0] cap_aw, cap_wd, cap_ar, wa, wd;
    logic [7:0] cap_ws, ws;
    int aw_wait, w_wait, ar_wait, aw_vc, w_vc;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rlast = 0; rdata = 0;
    got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; aw_vc = 0; w_vc = 0;
    wa = 0; wd = 0; ws = 0;
    forever begin
      @(negedge clk_i);
      awv = awvalid; wv = wvalid; arv = arvalid;
      aw_hs = awvalid && awready; w_hs = wvalid && wready; ar_hs = arvalid && arready;
      b_hs = bvalid && bready; r_hs = rvalid && rready;
      cap_aw = awaddr; cap_wd = wdata; cap_ws = wstrb; cap_ar = araddr; s_wlast = wlast;
      if (awv) aw_vc++;
      if (wv) w_vc++;
      @(posedge clk_i); #1;
      if (reset_i) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; aw_vc = 0; w_vc = 0;
        n_req = 0; n_done = 0;
        continue;
      end
      if (b_hs || r_hs) begin n_done++; bvalid = 0; rvalid = 0; end
      if (aw_hs) begin got_aw = 1; wa = cap_aw; aw_wait = 0; aw_vcyc = aw_vc; aw_vc = 0; end
      else if (awv) aw_wait++;
      if (w_hs) begin
        got_w = 1; wd = cap_wd; ws = cap_ws; w_wait = 0; w_vcyc = w_vc; w_vc = 0;
        check("wlast", 64'(s_wlast), 64'(1));
      end else if (wv) w_wait++;
      if (got_aw && got_w) begin
        check("req_is_wr", 64'(t_wr[n_req]), 64'(1));
        check("awaddr", wa, 64'({t_idx[n_req], 3'b000}));
        check("wdata", wd, t_data[n_req]);
        check("wstrb", 64'(ws), 64'(t_strb[n_req]));
        for (int b = 0; b < 8; b++) if (ws[b]) smem[wa[8:3]][b*8 +: 8] = wd[b*8 +: 8];
        s_last_awaddr = wa; s_last_wstrb = ws;
        bresp = inj_b[n_req]; bvalid = 1; n_req++;
        got_aw = 0; got_w = 0;
      end
      if (ar_hs) begin
        check("req_is_rd", 64'(t_wr[n_req]), 64'(0));
        check("araddr", cap_ar, 64'({t_idx[n_req], 3'b000}));
        rdata = smem[cap_ar[8:3]]; rresp = inj_rr[n_req]; rlast = !inj_rl0[n_req];
        rvalid = 1; n_req++; ar_wait = 0;
      end else if (arv) ar_wait++;
      awready = (aw_wait >= aw_stall);
      wready = (w_wait >= w_stall);
      arready = (ar_wait >= ar_stall);
    end
  end

  // Per-cycle compare against the trace-level model and the handshake history.
  bit pv_aw = 0, pv_w = 0, pv_ar = 0;
  logic [63:0] p_aw, p_wd, p_ar;
  always @(negedge clk_i) begin
    int od;
    bit busy, wr_o, rd_o;
    if (reset_i || !cmp_en) begin
      pv_aw = 0; pv_w = 0; pv_ar = 0;
    end else begin
      od = n_done;
      busy = (n_acc > od);
      wr_o = busy && t_wr[od];
      rd_o = busy && !t_wr[od];
      check("op_cnt", 64'(op_cnt_o), 64'(e_op[od]));
      check("mismatch_cnt", 64'(mismatch_cnt_o), 64'(e_mm[od]));
      check("error", 64'(error_o), 64'(e_err[od]));
      check("done", 64'(done_o), 64'(n_tr > 0 && od == n_tr));
      check("yumi", 64'(tr_yumi_o), 64'(tr_v_i && !busy && od < n_tr));
      check("aw_or_w_valid", 64'(awvalid | wvalid), 64'(wr_o && n_req == od));
      check("arvalid", 64'(arvalid), 64'(rd_o && n_req == od));
      check("bready", 64'(bready), 64'(wr_o && n_req == od + 1));
      check("rready", 64'(rready), 64'(rd_o && n_req == od + 1));
      if (pv_aw) begin check("awvalid_hold", 64'(awvalid), 64'(1)); check("awaddr_stable", awaddr, p_aw); end
      if (pv_w) begin check("wvalid_hold", 64'(wvalid), 64'(1)); check("wdata_stable", wdata, p_wd); end
      if (pv_ar) begin check("arvalid_hold", 64'(arvalid), 64'(1)); check("araddr_stable", araddr, p_ar); end
      pv_aw = awvalid && !awready; p_aw = awaddr;
      pv_w = wvalid && !wready; p_wd = wdata;
      pv_ar = arvalid && !arready; p_ar = araddr;
    end
  end

  initial begin : main
    int ys, vs, c;
    for (int i = 0; i < 64; i++) begin
      smem[i] = 64'hF0F0_F0F0_0000_0000 | 64'(i);
      mmem[i] = smem[i];
    end
    tr_v_i = 1; tr_wr_i = 1; tr_last_i = 0; tr_idx_i = 6'd9; tr_data_i = 64'h1; tr_strb_i = 8'hFF;
    reset_i = 1;
    #1;
    check("rst_yumi", 64'(tr_yumi_o), 0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    check("rst_done_err", 64'({done_o, error_o}), 0);
    check("rst_cnts", 64'({op_cnt_o, mismatch_cnt_o}), 0);
    check("rst_addr_data", awaddr | araddr | wdata | 64'(wstrb), 0);
    tr_v_i = 0;
    do_reset();
    cmp_en = 1;

    // write then read back, zero-wait slave
    n_tr = 2;
    set_entry(0, 1, 6'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    set_entry(1, 0, 6'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    build_model(); drive_all(0); wait_done(100);
    check("t1_awaddr", s_last_awaddr, 64'h28);
    check("t1_wstrb", 64'(s_last_wstrb), 64'hFF);
    check("t1_op_cnt", 64'(op_cnt_o), 2);
    check("t1_mismatch", 64'(mismatch_cnt_o), 0);
    check("t1_done_err", 64'({done_o, error_o}), 64'b10);
    check("t1_yumi_spacing", 64'(yumi_cyc[1] - yumi_cyc[0]), 3);

    // partial write, masked compare
    do_reset(); n_tr = 2;
    set_entry(0, 1, 6'd2, 64'h11223344_55667788, 8'h0F);
    set_entry(1, 0, 6'd2, 64'h00000000_55667788, 8'h0F);
    build_model(); drive_all(0); wait_done(100);
    check("t2_masked_match", 64'(mismatch_cnt_o), 0);
    do_reset(); n_tr = 1;
    set_entry(0, 0, 6'd2, 64'h00000000_55667788, 8'hFF);
    build_model(); drive_all(0); wait_done(100);
    check("t2_full_mismatch", 64'(mismatch_cnt_o), 1);

    // awready stalled, then wready stalled
    do_reset(); aw_stall = 2; n_tr = 2;
    set_entry(0, 1, 6'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
    set_entry(1, 0, 6'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
    build_model(); drive_all(0); wait_done(100);
    check("t3_aw_cycles", 64'(aw_vcyc), 3);
    check("t3_w_cycles", 64'(w_vcyc), 1);
    do_reset(); aw_stall = 0; w_stall = 2; n_tr = 2;
    set_entry(0, 1, 6'd4, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C);
    set_entry(1, 0, 6'd4, 64'h0000_5A5A_0F0F_0000, 8'h3C);
    build_model(); drive_all(0); wait_done(100);
    check("t3b_aw_cycles", 64'(aw_vcyc), 1);
    check("t3b_w_cycles", 64'(w_vcyc), 3);
    check("t3b_mismatch", 64'(mismatch_cnt_o), 0);
    w_stall = 0;

    // error responses early, sticky over the rest
    do_reset();
    gen_random(12, 0);
    set_entry(0, 1, 6'd6, 64'h77, 8'h01); inj_b[0] = 2'b10;
    set_entry(1, 0, 6'd6, 64'h77, 8'h01); inj_rl0[1] = 1;
    build_model(); drive_all(2); wait_done(500);
    check("t4_error", 64'(error_o), 1);
    check("t4_op_cnt", 64'(op_cnt_o), 12);

    // traffic offered after done is ignored
    ys = 0; vs = 0;
    for (int i = 0; i < 20; i++) begin
      tr_v_i = 1; tr_wr_i = 1'($urandom); tr_idx_i = 6'($urandom); tr_data_i = {$urandom, $urandom};
      @(negedge clk_i);
      if (tr_yumi_o) ys++;
      if (awvalid || wvalid || arvalid) vs++;
      @(posedge clk_i); #1;
    end
    tr_v_i = 0;
    check("t5_no_yumi", 64'(ys), 0);
    check("t5_no_valids", 64'(vs), 0);
    check("t5_op_cnt_kept", 64'(op_cnt_o), 12);

    // asynchronous reset while arvalid is held
    do_reset(); ar_stall = 6; n_tr = 2;
    set_entry(0, 1, 6'd8, 64'hFEED, 8'hFF);
    set_entry(1, 0, 6'd8, 64'hFEED, 8'hFF);
    build_model(); drive_all(0);
    c = 0;
    while (!arvalid && c < 20) begin @(negedge clk_i); c++; end
    check("t6_arvalid_seen", 64'(arvalid), 1);
    @(posedge clk_i); #2;
    reset_i = 1; n_acc = 0; n_tr = 0;
    #1;
    check("t6_arvalid_drop", 64'(arvalid), 0);
    check("t6_op_cnt_drop", 64'(op_cnt_o), 0);
    check("t6_done_drop", 64'(done_o), 0);
    @(posedge clk_i); #2 reset_i = 0;
    ar_stall = 0;
    @(posedge clk_i); #1;
    gen_random(4, 0); build_model(); drive_all(1); wait_done(200);
    check("t6_fresh_op_cnt", 64'(op_cnt_o), 4);

    // randomized traces with stalls, gaps and faults
    for (int r = 0; r < 3; r++) begin
      do_reset();
      aw_stall = $urandom_range(0, 2); w_stall = $urandom_range(0, 2); ar_stall = $urandom_range(0, 2);
      gen_random(20, 1); build_model(); drive_all(3); wait_done(2000);
      check("rand_op_cnt_sat", 64'(op_cnt_o), SAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
